// File: rtl/rv_alu_exec.sv
// rv_alu_exec: execute-stage ALU with valid/ready handshakes on both sides.
//
// Ops (alu_op_sel_i): 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed),
// 1100 NOR, 0011 SLL, 0100 SRL, 0101 SRA. Every other code is illegal: the result
// is 0 with illegal_o = 1.
//
// Build option: define RV_ALU_BARREL_SHIFT_EN to compute shifts with a single-cycle
// barrel shifter. Without it, shifts run on an iterative 1-bit-per-cycle shifter
// that stalls the input side. Results are identical in both builds.
//
// Ports:
//   clk_i, rst_n_i        clock (rising edge), asynchronous active-low reset
//   flush_i               synchronous flush; drops in-flight work and the output valid
//   in_valid_i/in_ready_o input handshake
//   alu_op_sel_i          operation code
//   op_a_i, op_b_i        operands; shift amount is op_b_i[SHW-1:0]
//   rd_i                  destination tag, carried through to rd_o
//   out_valid_o/out_ready_i output handshake
//   result_o, zero_o, illegal_o, rd_o  registered result and flags
//   busy_o                iterative shift in progress
module rv_alu_exec #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [3:0]      alu_op_sel_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [4:0]      rd_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            illegal_o,
  output logic [4:0]      rd_o,
  output logic            busy_o
);

  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSll = 4'b0011;
  localparam logic [3:0] OpSrl = 4'b0100;
  localparam logic [3:0] OpSra = 4'b0101;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpSlt = 4'b0111;
  localparam logic [3:0] OpNor = 4'b1100;

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic            op_illegal;
  logic            op_is_shift;
  logic            slot_free;
  logic            accept;

  logic            load_en;
  logic [XLEN-1:0] load_val;
  logic            load_ill;
  logic [4:0]      load_rd;

  logic            valid_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            illegal_q;
  logic [4:0]      rd_q;

  assign shamt     = op_b_i[SHW-1:0];
  assign slot_free = !valid_q || out_ready_i;
  assign accept    = in_valid_i && in_ready_o;

  // Single-cycle result for everything the FSM does not have to iterate on.
  always_comb begin
    alu_res     = '0;
    op_illegal  = 1'b0;
    op_is_shift = 1'b0;
    case (alu_op_sel_i)
      OpAnd: alu_res = op_a_i & op_b_i;
      OpOr:  alu_res = op_a_i | op_b_i;
      OpAdd: alu_res = op_a_i + op_b_i;
      OpSub: alu_res = op_a_i - op_b_i;
      OpSlt: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
      OpNor: alu_res = ~(op_a_i | op_b_i);
`ifdef RV_ALU_BARREL_SHIFT_EN
      OpSll: begin
        op_is_shift = 1'b1;
        alu_res     = op_a_i << shamt;
      end
      OpSrl: begin
        op_is_shift = 1'b1;
        alu_res     = op_a_i >> shamt;
      end
      OpSra: begin
        op_is_shift = 1'b1;
        alu_res     = $signed(op_a_i) >>> shamt;
      end
`else
      // Only the zero-shift case completes here; non-zero amounts go to the FSM.
      OpSll, OpSrl, OpSra: begin
        op_is_shift = 1'b1;
        alu_res     = op_a_i;
      end
`endif
      default: op_illegal = 1'b1;
    endcase
  end

`ifdef RV_ALU_BARREL_SHIFT_EN

  assign in_ready_o = slot_free && !flush_i;
  assign busy_o     = 1'b0;

  always_comb begin
    load_en  = accept;
    load_val = alu_res;
    load_ill = op_illegal;
    load_rd  = rd_i;
  end

`else

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [SHW-1:0] CntOne = SHW'(1);

  state_e          state_q;
  logic [XLEN-1:0] work_q;
  logic [SHW-1:0]  cnt_q;
  logic [3:0]      op_q;
  logic [4:0]      tag_q;
  logic [XLEN-1:0] shift_step;
  logic            shift_start;

  function automatic logic [XLEN-1:0] shift1(input logic [3:0] op, input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    case (op)
      OpSll:   r = {v[XLEN-2:0], 1'b0};
      OpSrl:   r = {1'b0, v[XLEN-1:1]};
      default: r = {v[XLEN-1], v[XLEN-1:1]};
    endcase
    return r;
  endfunction

  assign shift_step  = shift1(op_q, work_q);
  assign shift_start = op_is_shift && (shamt != '0);
  assign in_ready_o  = (state_q == StIdle) && slot_free && !flush_i;
  assign busy_o      = (state_q == StShift);

  always_comb begin
    load_en  = 1'b0;
    load_val = alu_res;
    load_ill = op_illegal;
    load_rd  = rd_i;
    unique case (state_q)
      StIdle: load_en = accept && !shift_start;
      // The last shift step writes straight to the output when the slot is free,
      // so an unstalled shift completes shamt + 1 cycles after accept.
      StShift: begin
        if (cnt_q == CntOne && slot_free) begin
          load_en  = 1'b1;
          load_val = shift_step;
          load_ill = 1'b0;
          load_rd  = tag_q;
        end
      end
      StDone: begin
        if (slot_free) begin
          load_en  = 1'b1;
          load_val = work_q;
          load_ill = 1'b0;
          load_rd  = tag_q;
        end
      end
      default: load_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      tag_q   <= '0;
    end else if (flush_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept && shift_start) begin
            work_q  <= op_a_i;
            op_q    <= alu_op_sel_i;
            tag_q   <= rd_i;
            cnt_q   <= shamt;
            state_q <= StShift;
          end
        end
        StShift: begin
          work_q <= shift_step;
          cnt_q  <= cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            // DONE only holds the finished value while downstream is stalled.
            state_q <= slot_free ? StIdle : StDone;
          end
        end
        StDone: begin
          if (slot_free) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      rd_q      <= '0;
    end else if (flush_i) begin
      // result_q is kept but no longer valid.
      valid_q <= 1'b0;
    end else begin
      if (out_ready_i) valid_q <= 1'b0;
      if (load_en) begin
        valid_q   <= 1'b1;
        result_q  <= load_val;
        zero_q    <= (load_val == '0);
        illegal_q <= load_ill;
        rd_q      <= load_rd;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign result_o    = result_q;
  assign zero_o      = zero_q;
  assign illegal_o   = illegal_q;
  assign rd_o        = rd_q;

endmodule

// File: tb/tb_rv_alu_exec.sv
module tb_rv_alu_exec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op_sel = 4'h0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic [4:0]  rd_out;
  logic        busy;

  rv_alu_exec #(.XLEN(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .alu_op_sel_i(op_sel), .op_a_i(op_a), .op_b_i(op_b), .rd_i(rd_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .zero_o(zero), .illegal_o(illegal), .rd_o(rd_out),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

`ifdef RV_ALU_BARREL_SHIFT_EN
  localparam logic [31:0] ExpSraLat  = 32'd1;
  localparam logic [31:0] ExpSraBusy = 32'd0;
  localparam logic [31:0] ExpFlBusy  = 32'd0;
`else
  localparam logic [31:0] ExpSraLat  = 32'd5;
  localparam logic [31:0] ExpSraBusy = 32'd4;
  localparam logic [31:0] ExpFlBusy  = 32'd1;
`endif

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    logic [4:0]  rd;
  } exp_t;

  vec_t vecs[18];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_miscompare = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference for the random vectors.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd);
    exp_t e;
    e.rd  = rd;
    e.ill = 1'b0;
    case (op)
      4'h0: e.res = a & b;
      4'h1: e.res = a | b;
      4'h2: e.res = a + b;
      4'h6: e.res = a - b;
      4'h7: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hC: e.res = ~(a | b);
      4'h3: e.res = a << b[4:0];
      4'h4: e.res = a >> b[4:0];
      4'h5: e.res = $signed(a) >>> b[4:0];
      default: begin
        e.res = '0;
        e.ill = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input bit push, input exp_t e);
    bit ok = 1'b0;
    in_valid = 1'b1;
    op_sel = op;
    op_a = a;
    op_b = b;
    rd_in = rd;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_miscompare++;
      $display("FAIL accept_timeout: got no in_ready expected in_ready within 200 cycles");
    end else if (push) begin
      sb.push_back(e);
    end
  endtask

  // Scoreboard monitor: a transfer happens at the posedge following this sample.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_miscompare++;
        $display("FAIL unexpected_output: got result %h expected no output", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("zero", {31'd0, zero}, {31'd0, (e.res == 32'd0)});
        chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
        chk("rd", {27'd0, rd_out}, {27'd0, e.rd});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500us");
    $fatal(1);
  end

  initial begin
    logic [3:0]  ops[12];
    logic [31:0] lat, busy_cnt, rdy_cnt, vcnt;
    exp_t        e;
    bit          seen;

    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hC, 4'h8, 4'hD, 4'hF};

    vecs[0]  = '{4'h2, 32'hFFFFFFFF, 32'h00000001, 5'd1,  32'h00000000, 1'b0};
    vecs[1]  = '{4'h7, 32'h80000000, 32'h00000001, 5'd2,  32'h00000001, 1'b0};
    vecs[2]  = '{4'h7, 32'h00000001, 32'h80000000, 5'd3,  32'h00000000, 1'b0};
    vecs[3]  = '{4'h6, 32'h00000005, 32'h00000007, 5'd4,  32'hFFFFFFFE, 1'b0};
    vecs[4]  = '{4'h0, 32'h0F0F0F0F, 32'h00FF00FF, 5'd5,  32'h000F000F, 1'b0};
    vecs[5]  = '{4'h1, 32'h0F0F0F0F, 32'h00FF00FF, 5'd6,  32'h0FFF0FFF, 1'b0};
    vecs[6]  = '{4'hC, 32'h0F0F0F0F, 32'h00FF00FF, 5'd8,  32'hF000F000, 1'b0};
    vecs[7]  = '{4'h5, 32'hF0000000, 32'h00000004, 5'd7,  32'hFF000000, 1'b0};
    vecs[8]  = '{4'h3, 32'h00000001, 32'h0000001F, 5'd9,  32'h80000000, 1'b0};
    vecs[9]  = '{4'h4, 32'h80000000, 32'h0000001F, 5'd10, 32'h00000001, 1'b0};
    vecs[10] = '{4'h5, 32'h80000000, 32'h0000001F, 5'd11, 32'hFFFFFFFF, 1'b0};
    vecs[11] = '{4'h3, 32'h12345678, 32'h00000000, 5'd12, 32'h12345678, 1'b0};
    vecs[12] = '{4'h4, 32'hA5A5A5A5, 32'h00000024, 5'd13, 32'h0A5A5A5A, 1'b0};
    vecs[13] = '{4'hF, 32'h12345678, 32'h9ABCDEF0, 5'd14, 32'h00000000, 1'b1};
    vecs[14] = '{4'h8, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 32'h00000000, 1'b1};
    vecs[15] = '{4'h2, 32'h7FFFFFFF, 32'h00000001, 5'd16, 32'h80000000, 1'b0};
    vecs[16] = '{4'h7, 32'hFFFFFFFF, 32'h00000000, 5'd17, 32'h00000001, 1'b0};
    vecs[17] = '{4'h7, 32'h00000000, 32'h00000000, 5'd31, 32'h00000000, 1'b0};

    // Reset values while reset is held.
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_rd", {27'd0, rd_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table, back to back.
    foreach (vecs[i]) begin
      e = '{vecs[i].res, vecs[i].ill, vecs[i].rd};
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b1, e);
    end

    // Random vectors against the reference model.
    for (int i = 0; i < 20; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      logic [4:0]  rd;
      op = ops[$urandom_range(0, 11)];
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom_range(0, 31));
      send(op, a, b, rd, 1'b1, model(op, a, b, rd));
    end
    repeat (40) @(posedge clk);
    #1;

    // SRA latency, busy and back-pressure on the input side.
    send(4'h5, 32'hF0000000, 32'd4, 5'd7, 1'b1, '{32'hFF000000, 1'b0, 5'd7});
    lat = 32'd0;
    busy_cnt = 32'd0;
    rdy_cnt = 32'd0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = 32'(c);
        break;
      end
      if (busy) busy_cnt++;
      if (in_ready) rdy_cnt++;
    end
    chk("sra_latency", lat, ExpSraLat);
    chk("sra_busy_cycles", busy_cnt, ExpSraBusy);
    chk("sra_in_ready_while_shifting", rdy_cnt, 32'd0);
    @(posedge clk);
    #1;

    // Output back-pressure: result held, then release and accept in the same cycle.
    out_ready = 1'b0;
    send(4'h0, 32'h0F0F0F0F, 32'h00FF00FF, 5'd3, 1'b1, '{32'h000F000F, 1'b0, 5'd3});
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bp_valid", {31'd0, seen}, 32'd1);
    vcnt = 32'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold_result", result, 32'h000F000F);
      chk("bp_hold_rd", {27'd0, rd_out}, 32'd3);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      if (out_valid) vcnt++;
    end
    chk("bp_hold_valid_cycles", vcnt, 32'd3);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    op_sel = 4'h2;
    op_a = 32'd1;
    op_b = 32'd2;
    rd_in = 5'd4;
    @(negedge clk);
    chk("bp_same_cycle_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sb.push_back('{32'd3, 1'b0, 5'd4});
    @(negedge clk);
    chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;

    // Flush on the third shift cycle of SLL by 20.
`ifdef RV_ALU_BARREL_SHIFT_EN
    send(4'h3, 32'h00000003, 32'd20, 5'd20, 1'b1, '{32'h00300000, 1'b0, 5'd20});
`else
    send(4'h3, 32'h00000003, 32'd20, 5'd20, 1'b0, '{32'h0, 1'b0, 5'd0});
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b1;
    op_sel = 4'h2;
    op_a = 32'd5;
    op_b = 32'd5;
    @(negedge clk);
    chk("flush_in_ready_forced", {31'd0, in_ready}, 32'd0);
    chk("flush_busy_before", {31'd0, busy}, ExpFlBusy);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_busy_after", {31'd0, busy}, 32'd0);
    chk("flush_in_ready_after", {31'd0, in_ready}, 32'd1);
    vcnt = 32'd0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    chk("flush_no_late_output", vcnt, 32'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of SRL by 10.
`ifdef RV_ALU_BARREL_SHIFT_EN
    send(4'h4, 32'hFFFF0000, 32'd10, 5'd9, 1'b1, '{32'h003FFFC0, 1'b0, 5'd9});
`else
    send(4'h4, 32'hFFFF0000, 32'd10, 5'd9, 1'b0, '{32'h0, 1'b0, 5'd0});
`endif
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_zero", {31'd0, zero}, 32'd0);
    chk("arst_illegal", {31'd0, illegal}, 32'd0);
    chk("arst_rd", {27'd0, rd_out}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    vcnt = 32'd0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    chk("arst_no_partial_output", vcnt, 32'd0);
    @(posedge clk);
    #1;
    send(4'h2, 32'd10, 32'd20, 5'd21, 1'b1, '{32'd30, 1'b0, 5'd21});
    send(4'h5, 32'h80000000, 32'd1, 5'd22, 1'b1, '{32'hC0000000, 1'b0, 5'd22});
    repeat (10) @(posedge clk);
    #1;

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miscompare);
    $finish;
  end

endmodule
